// File: rtl/hazard_controller.sv
// Pipeline sequencer for the 5-stage rv32i core: derives PC and pipeline-register
// enables, flushes and bubbles from load-use hazards, cache stalls and branch
// mispredicts, and keeps saturating performance counters.
module hazard_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_mispredict,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             if_capture,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [0:0] {StRun, StWait} state_e;

  state_e state_q, state_d;
  logic   i_done_q, i_done_d;
  logic   d_done_q, d_done_d;

  logic [CNT_W-1:0] stall_q, bubble_q, flush_q;

  logic i_ok, d_ok, advance;
  logic rs1_hit, rs2_hit, load_use;
  logic do_flush, do_bubble;

  // A side is ready when it has nothing outstanding, answers now, or answered earlier
  // in the current stall.
  assign i_ok    = !imem_read | imem_resp | i_done_q;
  assign d_ok    = !dmem_req | dmem_resp | d_done_q;
  assign advance = i_ok & d_ok;

  assign rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
  assign load_use = ex_mem_read & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

  // Mispredict wins over load-use: the dependent ID instruction is squashed anyway.
  assign do_flush  = advance & ex_mispredict;
  assign do_bubble = advance & !ex_mispredict & load_use;

  // Next-state: leave the stall on advance, otherwise accumulate early responses.
  // Responses without a matching request never set a done flag.
  always_comb begin
    state_d  = state_q;
    i_done_d = i_done_q;
    d_done_d = d_done_q;
    if (advance) begin
      state_d  = StRun;
      i_done_d = 1'b0;
      d_done_d = 1'b0;
    end else begin
      state_d  = StWait;
      i_done_d = i_done_q | (imem_resp & imem_read);
      d_done_d = d_done_q | (dmem_resp & dmem_req);
    end
  end

  // State and done-flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StRun;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
    end
  end

  // Enable/flush decode; everything is forced low while reset is asserted.
  always_comb begin
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if_capture  = 1'b0;
    if (rst) begin
      if_capture = imem_resp & !advance;
      if (advance) begin
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        if (ex_mispredict) begin
          load_pc     = 1'b1;
          load_if_id  = 1'b1;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (load_use) begin
          flush_id_ex = 1'b1;
        end else begin
          load_pc    = 1'b1;
          load_if_id = 1'b1;
        end
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (!advance && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (do_bubble && !(&bubble_q)) bubble_q <= bubble_q + 1'b1;
      if (do_flush && !(&flush_q)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign bubble_count = bubble_q;
  assign flush_count  = flush_q;

endmodule
